// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, control-word bit layout and the bubble control value.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 8;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_ALU_OP_W   = 2;

  // All-zero control: no register write, no memory access, no branch.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold) and flush (bubble); priority rst > flush > stall > load.
// Optional stall/bubble saturating counters built when ID_EX_PERF_CNT_EN is defined.
module id_ex_reg #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int RA_W   = pipe_pkg::RA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  import pipe_pkg::*;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RA_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              load_bubble;

  // Bubble whenever reset/flush, or a load of an empty decode slot (id_* may be X then).
  assign load_bubble = rst || flush || (!stall && !id_valid);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      pc_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      ctrl_d  = CTRL_W'(BUBBLE_CTRL);
    end else if (!stall) begin
      valid_d = 1'b1;
      pc_d    = id_pc;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
      ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    pc_q    <= pc_d;
    rd1_q   <= rd1_d;
    rd2_q   <= rd2_d;
    imm_q   <= imm_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    rd_q    <= rd_d;
    ctrl_q  <= ctrl_d;
  end

  assign ex_valid = valid_q;
  assign ex_pc    = pc_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_rs1   = rs1_q;
  assign ex_rs2   = rs2_q;
  assign ex_rd    = rd_q;
  assign ex_ctrl  = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
  logic stall_inc, bubble_inc;

  assign stall_inc  = !rst && stall && !flush;
  assign bubble_inc = !rst && load_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall_inc),
    .clr   (rst),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .inc   (bubble_inc),
    .clr   (rst),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: behavioural next-value model checked every cycle, plus directed literal checks.
module tb_id_ex_reg;

  localparam int XLEN = 32, RA_W = 5, CTRL_W = 8, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [RA_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [CTRL_W-1:0] id_ctrl = '0;
  logic ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

  id_ex_reg #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage holds the last instruction that entered, or nothing.
  logic m_valid;
  logic [XLEN-1:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [RA_W-1:0] m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int m_stalls, m_bubbles;

  always @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl} <= '0;
    end else if (!stall) begin
      m_valid <= 1'b1; m_pc <= id_pc; m_rd1 <= id_rd1; m_rd2 <= id_rd2; m_imm <= id_imm;
      m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd; m_ctrl <= id_ctrl;
    end
    if (rst) begin
      m_stalls <= 0;
      m_bubbles <= 0;
    end else begin
      if (stall && !flush) m_stalls <= (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
      if (flush || (!stall && !id_valid)) m_bubbles <= (m_bubbles < CNT_MAX) ? m_bubbles + 1 : CNT_MAX;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(ex_valid), 64'(m_valid));
      chk("pc",    64'(ex_pc),    64'(m_pc));
      chk("rd1",   64'(ex_rd1),   64'(m_rd1));
      chk("rd2",   64'(ex_rd2),   64'(m_rd2));
      chk("imm",   64'(ex_imm),   64'(m_imm));
      chk("rs1",   64'(ex_rs1),   64'(m_rs1));
      chk("rs2",   64'(ex_rs2),   64'(m_rs2));
      chk("rd",    64'(ex_rd),    64'(m_rd));
      chk("ctrl",  64'(ex_ctrl),  64'(m_ctrl));
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt",  64'(stall_cnt),  64'(m_stalls));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubbles));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_id();
    id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1 = RA_W'($urandom); id_rs2 = RA_W'($urandom); id_rd = RA_W'($urandom);
    id_ctrl = CTRL_W'($urandom);
  endtask

  initial begin
    // Reset with random inputs
    @(negedge clk);
    rand_id(); id_valid = 1'b1; rst = 1'b1;
    tick();
    chk_en = 1'b1;
    rand_id();
    tick();
    chk("rst_valid", 64'(ex_valid), 64'h0);
    chk("rst_pc",    64'(ex_pc),    64'h0);
    chk("rst_ctrl",  64'(ex_ctrl),  64'h0);
    rst = 1'b0; id_pc = 32'h40;
    tick();
    chk("first_load_pc",    64'(ex_pc),    64'h40);
    chk("first_load_valid", 64'(ex_valid), 64'h1);

    // Normal flow
    rand_id();
    id_pc = 32'h100; id_imm = 32'hFFFF_FFF4; id_rd = 5'd5; id_ctrl = 8'h81; id_valid = 1'b1;
    tick();
    chk("norm_pc",    64'(ex_pc),    64'h100);
    chk("norm_imm",   64'(ex_imm),   64'hFFFF_FFF4);
    chk("norm_rd",    64'(ex_rd),    64'h5);
    chk("norm_ctrl",  64'(ex_ctrl),  64'h81);
    chk("norm_valid", 64'(ex_valid), 64'h1);

    // Stall holds for three cycles
    id_pc = 32'h200;
    tick();
    stall = 1'b1; id_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", 64'(ex_pc), 64'h200);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt_3", 64'(stall_cnt), 64'h3);
`endif
    stall = 1'b0;
    tick();
    chk("stall_release_pc", 64'(ex_pc), 64'h204);

    // Flush together with stall
    id_pc = 32'h300; id_rd = 5'd9; id_ctrl = 8'h3C;
    tick();
    chk("pre_flush_valid", 64'(ex_valid), 64'h1);
    flush = 1'b1; stall = 1'b1;
    tick();
    chk("flush_valid", 64'(ex_valid), 64'h0);
    chk("flush_ctrl",  64'(ex_ctrl),  64'h0);
    chk("flush_rd",    64'(ex_rd),    64'h0);
`ifdef ID_EX_PERF_CNT_EN
    chk("flush_bubble_cnt", 64'(bubble_cnt), 64'h1);
    chk("flush_stall_cnt",  64'(stall_cnt),  64'h3);
`endif
    flush = 1'b0; stall = 1'b0;

    // Invalid decode slot
    id_valid = 1'b0; id_ctrl = 8'hFF; id_rd = 5'd7;
    tick();
    chk("inv_ctrl",  64'(ex_ctrl),  64'h0);
    chk("inv_rd",    64'(ex_rd),    64'h0);
    chk("inv_valid", 64'(ex_valid), 64'h0);
`ifdef ID_EX_PERF_CNT_EN
    chk("inv_bubble_cnt", 64'(bubble_cnt), 64'h2);
`endif

    // Reset during a stall
    id_valid = 1'b1; id_pc = 32'h400;
    tick();
    stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_stall_valid", 64'(ex_valid), 64'h0);
    chk("rst_stall_pc",    64'(ex_pc),    64'h0);
    rst = 1'b0;

    // Counter saturation, then clear
    for (int i = 0; i < 20; i++) tick();
    chk("stall_hold_after_rst", 64'(ex_pc), 64'h0);
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
    stall = 1'b0; rst = 1'b1;
    tick();
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt_clr", 64'(stall_cnt), 64'h0);
`endif
    rst = 1'b0;

    // Random mix, checked by the model
    for (int i = 0; i < 300; i++) begin
      rand_id();
      id_valid = ($urandom_range(3) != 0);
      stall    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(7) == 0);
      rst      = ($urandom_range(31) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage processor. Captures the decode-stage bundle each cycle and presents it to execute for one cycle. The bundle holds the PC, both register-file read values, the 32-bit sign-extended immediate from `extend`, register addresses and the control word. It implements stall (hold) and flush (bubble insertion) for the hazard unit, and optionally counts stall and bubble cycles.

## Interface
Parameters:
- `XLEN`, 32, datapath width (PC, operands, immediate)
- `RA_W`, 5, register address width
- `CTRL_W`, 8, control word width
- `CNT_W`, 32, performance counter width (used only with `ID_EX_PERF_CNT_EN`)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold current contents
- `flush`  in  1  replace contents with a bubble
- `id_valid`  in  1  decode slot holds a real instruction
- `id_pc`  in  XLEN  instruction PC
- `id_rd1`, `id_rd2`  in  XLEN  register-file read data
- `id_imm`  in  XLEN  sign-extended immediate
- `id_rs1`, `id_rs2`, `id_rd`  in  RA_W  source/destination addresses
- `id_ctrl`  in  CTRL_W  decoded control word
- `ex_valid`  out  1  registered valid
- `ex_pc`, `ex_rd1`, `ex_rd2`, `ex_imm`  out  XLEN  registered copies
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  RA_W  registered copies
- `ex_ctrl`  out  CTRL_W  registered control
- `stall_cnt`, `bubble_cnt`  out  CNT_W  counters (present only with `ID_EX_PERF_CNT_EN`)

## Operation
- Per-edge priority: `rst` > `flush` > `stall` > load.
- Reset: every output is 0, including `ex_valid`, `ex_ctrl` and the counters.
- Flush: a bubble is loaded.
  - Bubble: `ex_valid`=0; every data, address and control field = 0.
  - `ex_rd`=0 and `ex_ctrl`=0 guarantee no register write, no memory access and no forwarding match.
- Stall (without flush): all outputs hold their previous values, including `ex_valid`.
- Load: all `ex_*` take the corresponding `id_*` values.
  - If `id_valid`=0, a bubble is loaded instead. Inputs are ignored and no X is propagated.
- Fields pass through unmodified. The block performs no arithmetic on the datapath; `ex_imm` is exactly `id_imm`.
- Flush and stall asserted together: flush wins and a bubble is inserted. This is a legal combination (branch resolution during a load-use stall).
- Reset mid-stall: the register clears. The stall has no effect until `rst` deasserts.

## Timing
- Latency: exactly one cycle from `id_*` to `ex_*` on a load.
- Outputs are purely registered, with no combinational path from any input to any output.
- `stall` and `flush` are sampled at the same edge as the data.
- After `rst` deasserts, the first edge can load.
- No handshake beyond stall/flush. The upstream stage must hold its own outputs while `stall`=1.

## Configuration
- `ID_EX_PERF_CNT_EN` defined: ports `stall_cnt` and `bubble_cnt` and two CNT_W saturating counters are built.
  - `stall_cnt` increments on each edge with `stall`=1, `flush`=0, `rst`=0.
  - `bubble_cnt` increments on each edge where a bubble is loaded: `flush`=1, or a load with `id_valid`=0.
  - Both counters saturate at all-ones and never wrap.
  - Both counters clear on `rst`.
- `ID_EX_PERF_CNT_EN` undefined: counters and their ports are absent. Register behaviour is identical in both builds.

## Structure
- Shared package `pipe_pkg` holds:
  - `XLEN`, `RA_W`, `CTRL_W`
  - control-word bit indices: `CTRL_REG_WRITE`, `CTRL_MEM_READ`, `CTRL_MEM_WRITE`, `CTRL_MEM_TO_REG`, `CTRL_ALU_SRC`, `CTRL_BRANCH`, and the `CTRL_ALU_OP` field
  - the `BUBBLE_CTRL` constant (all zeros)
- The other pipeline registers (IF/ID, EX/MEM, MEM/WB) reuse the package.
- One sub-module: `sat_counter` (parameter width; ports inc, clr, count). It is instantiated twice when `ID_EX_PERF_CNT_EN` is defined.

## Test plan
- Reset: drive random `id_*`, `rst`=1 for 2 cycles -> all outputs 0; the first load after release gives `ex_pc`=`id_pc`.
- Normal flow: `id_pc`=0x100, `id_imm`=0xFFFF_FFF4, `id_rd`=5, `id_ctrl`=0x81, `id_valid`=1 -> next cycle `ex_pc`=0x100, `ex_imm`=0xFFFF_FFF4, `ex_rd`=5, `ex_ctrl`=0x81, `ex_valid`=1.
- Stall: load PC 0x200, then `stall`=1 for 3 cycles while `id_pc` changes to 0x204 -> `ex_pc` stays 0x200 for all 3 cycles; `stall_cnt`=3 (with the macro).
- Flush with stall: `ex_valid`=1 with PC 0x300, assert `flush`=1 and `stall`=1 -> next cycle `ex_valid`=0, `ex_ctrl`=0, `ex_rd`=0; `bubble_cnt`+1, `stall_cnt` unchanged.
- Invalid input: `id_valid`=0 with `id_ctrl`=0xFF, `id_rd`=7 -> `ex_ctrl`=0, `ex_rd`=0, `ex_valid`=0.
- Saturation (macro on, `CNT_W`=4): hold `stall`=1 for 20 cycles -> `stall_cnt` stops at 15; `rst` -> 0.
